// File: rtl/vram_pixel_writer.sv
// Pixel write engine: turns plot/clear command pulses into frame-buffer writes,
// stalling on the VRAM write grant shared with display scan-out.
module vram_pixel_writer #(
   parameter int H_RES   = 160,
   parameter int V_RES   = 120,
   parameter int ADDR_W  = 15,
   parameter int COLOR_W = 9
) (
   input  logic               clk,
   input  logic               RST,
   input  logic [7:0]         Xin,
   input  logic [7:0]         Yin,
   input  logic [COLOR_W-1:0] RGBin,
   input  logic               plot,
   input  logic               clear,
   input  logic               vram_gnt,
   output logic               vram_we,
   output logic [ADDR_W-1:0]  vram_addr,
   output logic [COLOR_W-1:0] vram_data,
   output logic               busy,
   output logic               done,
   output logic               oob_err
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
   localparam logic [8:0]        X_LIM     = 9'(H_RES);
   localparam logic [8:0]        Y_LIM     = 9'(V_RES);

   typedef enum logic [1:0] {IDLE, PLOT, FILL, DONE} state_t;

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [COLOR_W-1:0]   data_q, data_d;
   logic                 we_q, we_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 oob_q, oob_d;

   logic [ADDR_W-1:0]    plot_addr;
   logic                 plot_oob;

   // Widened to ADDR_W before multiplying so legal coordinates cannot overflow.
   assign plot_addr = ADDR_W'(Yin) * ADDR_W'(H_RES) + ADDR_W'(Xin);
   assign plot_oob  = ({1'b0, Xin} >= X_LIM) || ({1'b0, Yin} >= Y_LIM);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      we_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      oob_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (clear) begin
               state_d = FILL;
               addr_d  = '0;
               data_d  = RGBin;
               we_d    = 1'b1;
               busy_d  = 1'b1;
            end else if (plot) begin
               if (plot_oob) begin
                  oob_d = 1'b1;
               end else begin
                  state_d = PLOT;
                  addr_d  = plot_addr;
                  data_d  = RGBin;
                  we_d    = 1'b1;
                  busy_d  = 1'b1;
               end
            end
         end
         PLOT: begin
            we_d   = 1'b1;
            busy_d = 1'b1;
            if (vram_gnt) begin
               state_d = DONE;
               we_d    = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         FILL: begin
            we_d   = 1'b1;
            busy_d = 1'b1;
            // The fill counter is the write address itself; it only moves on a commit.
            if (vram_gnt) begin
               if (addr_q == LAST_ADDR) begin
                  state_d = DONE;
                  we_d    = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         oob_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         oob_q   <= oob_d;
      end
   end

   assign vram_we   = we_q;
   assign vram_addr = addr_q;
   assign vram_data = data_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign oob_err   = oob_q;

endmodule

// File: tb/tb_vram_pixel_writer.sv
// Directed bench for vram_pixel_writer: plot, stalled plot, out-of-range plot,
// full-screen clear with grant stall, command collision and reset mid-fill.
module tb_vram_pixel_writer;

   localparam int NPIX = 160 * 120;

   logic        clk = 1'b0;
   logic        RST;
   logic [7:0]  Xin, Yin;
   logic [8:0]  RGBin;
   logic        plot, clear, vram_gnt;
   logic        vram_we;
   logic [14:0] vram_addr;
   logic [8:0]  vram_data;
   logic        busy, done, oob_err;

   int tests = 0;
   int fails = 0;

   vram_pixel_writer dut (
      .clk(clk), .RST(RST), .Xin(Xin), .Yin(Yin), .RGBin(RGBin),
      .plot(plot), .clear(clear), .vram_gnt(vram_gnt),
      .vram_we(vram_we), .vram_addr(vram_addr), .vram_data(vram_data),
      .busy(busy), .done(done), .oob_err(oob_err)
   );

   always #5 clk = ~clk;

   // Advance one cycle; outputs are then observed 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1; plot = 1'b0; clear = 1'b0; vram_gnt = 1'b0;
      Xin = '0; Yin = '0; RGBin = '0;
      tick(); tick();
      RST = 1'b0;
      tests++; if (vram_we !== 1'b0)    begin fails++; $display("FAIL reset_we got %b want 0", vram_we); end
      tests++; if (busy !== 1'b0)       begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
      tests++; if (done !== 1'b0)       begin fails++; $display("FAIL reset_done got %b want 0", done); end
      tests++; if (oob_err !== 1'b0)    begin fails++; $display("FAIL reset_oob got %b want 0", oob_err); end
      tests++; if (vram_addr !== 15'd0) begin fails++; $display("FAIL reset_addr got %0d want 0", vram_addr); end
      tests++; if (vram_data !== 9'd0)  begin fails++; $display("FAIL reset_data got %h want 0", vram_data); end
      $display("[TB] reset: we=%b busy=%b addr=%0d", vram_we, busy, vram_addr);
   endtask

   task automatic test_plot_grant();
      vram_gnt = 1'b1; Xin = 8'd10; Yin = 8'd20; RGBin = 9'h1B6; plot = 1'b1;
      tick();
      plot = 1'b0;
      tests++; if (vram_we !== 1'b1)       begin fails++; $display("FAIL plot_we got %b want 1", vram_we); end
      tests++; if (vram_addr !== 15'd3210) begin fails++; $display("FAIL plot_addr got %0d want 3210", vram_addr); end
      tests++; if (vram_data !== 9'h1B6)   begin fails++; $display("FAIL plot_data got %h want 1b6", vram_data); end
      tests++; if (busy !== 1'b1)          begin fails++; $display("FAIL plot_busy got %b want 1", busy); end
      tick();
      tests++; if (vram_we !== 1'b0)       begin fails++; $display("FAIL plot_we_off got %b want 0", vram_we); end
      tests++; if (done !== 1'b1)          begin fails++; $display("FAIL plot_done got %b want 1", done); end
      tests++; if (busy !== 1'b0)          begin fails++; $display("FAIL plot_busy_off got %b want 0", busy); end
      tick();
      tests++; if (done !== 1'b0)          begin fails++; $display("FAIL plot_done_pulse got %b want 0", done); end
      $display("[TB] plot (10,20) rgb=1b6 grant=1 done");
   endtask

   task automatic test_plot_wait();
      vram_gnt = 1'b0; Xin = 8'd10; Yin = 8'd20; RGBin = 9'h1B6; plot = 1'b1;
      tick();
      plot = 1'b0;
      Xin = 8'd99; RGBin = 9'h011;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) vram_gnt = 1'b1;
         tests++;
         if (vram_we !== 1'b1 || vram_addr !== 15'd3210 || vram_data !== 9'h1B6 || done !== 1'b0) begin
            fails++;
            $display("FAIL wait_hold[%0d] got we=%b addr=%0d data=%h done=%b want we=1 addr=3210 data=1b6 done=0",
                     i, vram_we, vram_addr, vram_data, done);
         end
         tick();
      end
      tests++; if (done !== 1'b1 || vram_we !== 1'b0) begin
         fails++; $display("FAIL wait_done got done=%b we=%b want done=1 we=0", done, vram_we);
      end
      tick();
      $display("[TB] plot with 3 stall cycles then grant");
   endtask

   task automatic test_oob();
      logic [7:0] xs [2];
      logic [7:0] ys [2];
      xs[0] = 8'd160; ys[0] = 8'd5;
      xs[1] = 8'd3;   ys[1] = 8'd120;
      vram_gnt = 1'b1;
      for (int i = 0; i < 2; i++) begin
         Xin = xs[i]; Yin = ys[i]; RGBin = 9'h0F0; plot = 1'b1;
         tick();
         plot = 1'b0;
         tests++; if (oob_err !== 1'b1 || vram_we !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL oob_pulse[%0d] got oob=%b we=%b busy=%b want 1 0 0", i, oob_err, vram_we, busy);
         end
         tick();
         tests++; if (oob_err !== 1'b0 || done !== 1'b0 || vram_we !== 1'b0) begin
            fails++; $display("FAIL oob_after[%0d] got oob=%b done=%b we=%b want 0 0 0", i, oob_err, done, vram_we);
         end
         $display("[TB] oob plot (%0d,%0d) rejected", xs[i], ys[i]);
      end
      Xin = 8'd0; Yin = 8'd1; RGBin = 9'h055; plot = 1'b1;
      tick();
      plot = 1'b0;
      tests++; if (vram_we !== 1'b1 || vram_addr !== 15'd160 || vram_data !== 9'h055) begin
         fails++; $display("FAIL oob_recover got we=%b addr=%0d data=%h want 1 160 055", vram_we, vram_addr, vram_data);
      end
      tick(); tick();
      $display("[TB] legal plot (0,1) after oob");
   endtask

   task automatic test_clear();
      int exp_addr = 0;
      int writes = 0;
      int drops = 0;
      int done_cyc = -1;
      logic bad = 1'b0;
      vram_gnt = 1'b1; RGBin = 9'h000; clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int c = 1; c < 25000 && done_cyc < 0; c++) begin
         plot = (exp_addr == 50);
         Xin = 8'd5; Yin = 8'd5; RGBin = 9'h1FF;
         if (exp_addr == 100 && drops < 5) begin
            vram_gnt = 1'b0; drops++;
         end else begin
            vram_gnt = 1'b1;
         end
         if (done === 1'b1) begin
            done_cyc = c;
            if (vram_we !== 1'b0 && !bad) begin
               bad = 1'b1; $display("FAIL clear_we_in_done got we=%b want 0", vram_we);
            end
         end else if (vram_we === 1'b1) begin
            if ((vram_addr !== 15'(exp_addr) || vram_data !== 9'h000) && !bad) begin
               bad = 1'b1;
               $display("FAIL clear_seq got addr=%0d data=%h want addr=%0d data=000", vram_addr, vram_data, exp_addr);
            end
            if (vram_gnt) begin
               writes++; exp_addr++;
            end
         end
         tick();
      end
      plot = 1'b0; vram_gnt = 1'b1;
      tests++; if (bad) fails++;
      tests++; if (writes !== NPIX) begin fails++; $display("FAIL clear_writes got %0d want %0d", writes, NPIX); end
      tests++; if (done_cyc !== NPIX + 1 + 5) begin
         fails++; $display("FAIL clear_done_cycle got %0d want %0d", done_cyc, NPIX + 6);
      end
      tests++; if (vram_we !== 1'b0 || busy !== 1'b0) begin
         fails++; $display("FAIL clear_idle got we=%b busy=%b want 0 0", vram_we, busy);
      end
      $display("[TB] clear: %0d writes, done at k+%0d", writes, done_cyc);
   endtask

   task automatic test_plot_clear_both();
      int exp_addr = 0;
      int writes = 0;
      logic seen_done = 1'b0;
      logic bad = 1'b0;
      vram_gnt = 1'b1; Xin = 8'd10; Yin = 8'd20; RGBin = 9'h1FF; plot = 1'b1; clear = 1'b1;
      tick();
      plot = 1'b0; clear = 1'b0; RGBin = 9'h000;
      for (int c = 0; c < 20000 && !seen_done; c++) begin
         if (done === 1'b1) begin
            seen_done = 1'b1;
         end else if (vram_we === 1'b1) begin
            if ((vram_addr !== 15'(exp_addr) || vram_data !== 9'h1FF) && !bad) begin
               bad = 1'b1;
               $display("FAIL both_seq got addr=%0d data=%h want addr=%0d data=1ff", vram_addr, vram_data, exp_addr);
            end
            writes++; exp_addr++;
         end
         tick();
      end
      tests++; if (bad) fails++;
      tests++; if (writes !== NPIX || !seen_done) begin
         fails++; $display("FAIL both_writes got %0d done=%b want %0d done=1", writes, seen_done, NPIX);
      end
      $display("[TB] plot+clear together: fill of %0d writes", writes);
   endtask

   task automatic test_reset_mid_fill();
      logic reached = 1'b0;
      vram_gnt = 1'b1; RGBin = 9'h0C3; clear = 1'b1;
      tick();
      clear = 1'b0;
      for (int c = 0; c < 1000 && !reached; c++) begin
         if (vram_addr === 15'd500) reached = 1'b1;
         else tick();
      end
      tests++; if (!reached) begin fails++; $display("FAIL rst_fill_reach got addr=%0d want 500", vram_addr); end
      RST = 1'b1;
      tick();
      RST = 1'b0;
      tests++; if (vram_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || vram_addr !== 15'd0) begin
         fails++; $display("FAIL rst_fill got we=%b busy=%b done=%b addr=%0d want 0 0 0 0",
                           vram_we, busy, done, vram_addr);
      end
      Xin = 8'd0; Yin = 8'd0; RGBin = 9'h0AA; plot = 1'b1;
      tick();
      plot = 1'b0;
      tests++; if (vram_we !== 1'b1 || vram_addr !== 15'd0 || vram_data !== 9'h0AA) begin
         fails++; $display("FAIL rst_replot got we=%b addr=%0d data=%h want 1 0 0aa", vram_we, vram_addr, vram_data);
      end
      tick();
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL rst_replot_done got %b want 1", done); end
      $display("[TB] reset at fill address 500, then plot (0,0)");
   endtask

   initial begin
      test_reset();
      test_plot_grant();
      test_plot_wait();
      test_oob();
      test_clear();
      test_plot_clear_both();
      test_reset_mid_fill();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vram_pixel_writer.md
Name: vram_pixel_writer

Overview:
- Consumer side of the X/Y/RGB operator-input path: takes latched Xin/Yin/RGBin plus plot/clear command pulses and writes pixels into the frame-buffer write port.
- Arbitrates with the display scan-out through a grant handshake.
- Supports single-pixel plot and full-screen fill.
- Sits between the switch/key input latch and the dual-port VRAM feeding the VGA scanner.

Parameters:
- H_RES, 160, horizontal pixels; legal X range 0..H_RES-1
- V_RES, 120, vertical pixels; legal Y range 0..V_RES-1
- ADDR_W, 15, VRAM address width; must satisfy 2^ADDR_W >= H_RES*V_RES
- COLOR_W, 9, pixel width (3:3:3 RGB)

Ports:
- clk  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous reset, active-high
- Xin  in  8  pixel X coordinate
- Yin  in  8  pixel Y coordinate
- RGBin  in  COLOR_W  pixel colour / fill colour
- plot  in  1  single-cycle command pulse: write one pixel
- clear  in  1  single-cycle command pulse: fill whole screen with RGBin
- vram_gnt  in  1  VRAM write port granted this cycle
- vram_we  out  1  write request; the write commits in a cycle with vram_we=1 and vram_gnt=1
- vram_addr  out  ADDR_W  write address = Y*H_RES + X
- vram_data  out  COLOR_W  write data
- busy  out  1  command in progress
- done  out  1  one-cycle pulse after the last write of a command
- oob_err  out  1  one-cycle pulse: plot rejected because the coordinate is out of range

Behaviour:
- Reset (RST=1 at a clock edge): state IDLE; vram_we, busy, done and oob_err = 0; vram_addr and vram_data = 0; fill counter = 0.
- Reset takes effect at the next edge from any state. A partial clear is abandoned and VRAM contents are left as written.
- States: IDLE, PLOT, FILL, DONE.
- IDLE:
  - Samples plot and clear each cycle.
  - clear=1 has priority over plot when both are high in the same cycle.
  - Commands arriving outside IDLE are ignored, with no queueing.
- Plot accepted in cycle k (IDLE, plot=1, clear=0):
  - If Xin >= H_RES or Yin >= V_RES: oob_err=1 in cycle k+1; no write; no done; stays IDLE.
  - Otherwise, in cycle k+1: PLOT; vram_we=1; busy=1; vram_addr = Yin*H_RES+Xin, computed at ADDR_W width with no overflow for legal inputs; vram_data = RGBin sampled in cycle k.
- PLOT:
  - vram_we, vram_addr and vram_data are held stable while vram_gnt=0.
  - In the first cycle with vram_gnt=1 the write commits.
  - Next state is DONE.
- Clear accepted in cycle k:
  - Fill colour latched from RGBin in cycle k.
  - From cycle k+1: FILL; busy=1; vram_we=1; vram_addr starts at 0; vram_data = fill colour.
- FILL:
  - The address advances by 1 only on cycles with vram_gnt=1. It holds otherwise.
  - After the commit at address H_RES*V_RES-1, next state is DONE.
  - With vram_gnt held at 1: H_RES*V_RES consecutive write cycles, addresses 0..H_RES*V_RES-1.
- DONE (one cycle): done=1, vram_we=0, busy=0; next state IDLE.
  - A plot or clear pulse in the DONE cycle is ignored.
  - Plot latency with grant: done in cycle k+2.
  - Clear latency with grant: done in cycle k+H_RES*V_RES+1.
- Input sampling:
  - Xin, Yin and RGBin are sampled only at command acceptance.
  - Changes while busy do not affect the write in progress.
- vram_we is never 1 in IDLE or DONE. vram_addr never exceeds H_RES*V_RES-1 while vram_we=1.

Test Plan:
- Plot X=10, Y=20, RGBin=9'h1B6, vram_gnt=1 -> vram_we=1 for exactly 1 cycle with addr=3210, data=9'h1B6; done 1 cycle later; busy high exactly 1 cycle.
- Same plot with vram_gnt=0 for 3 cycles then 1 -> vram_we high 4 cycles, addr/data stable throughout, done in the cycle after the grant; changing Xin mid-wait has no effect.
- Plot X=160, Y=5 (and separately X=3, Y=120) -> no vram_we, oob_err pulses once, done stays 0, module returns to IDLE and the next legal plot works.
- Clear with RGBin=9'h000, vram_gnt=1 -> 19200 writes, addresses 0..19199 in order, data 0, done at k+19201; plot pulses during the fill are ignored; grant dropped at address 100 for 5 cycles -> address holds at 100.
- plot and clear high in the same cycle -> full fill performed, no single-pixel write.
- RST=1 during the fill at address 500 -> next cycle vram_we=0, busy=0, done=0, vram_addr=0; a following plot at (0,0) writes address 0 normally.
